// File: rtl/esp8266_encode_if.sv
// Handshake bundle between the ESP8266 command encoder, the application,
// and the UART TX/RX byte engines.
interface esp8266_encode_if;
    logic        send;
    logic [23:0] payload;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        rx_int;
    logic [7:0]  rx_data;
    logic        busy;
    logic        done;
    logic        timeout;

    modport master (
        output send, payload, tx_busy, rx_int, rx_data,
        input  tx_start, tx_data, busy, done, timeout
    );

    modport slave (
        input  send, payload, tx_busy, rx_int, rx_data,
        output tx_start, tx_data, busy, done, timeout
    );
endinterface

// File: rtl/esp8266_encode.sv
// Sends "AT+CIPSEND=3\r\n", waits for the '>' prompt on the RX stream,
// then sends a latched 3-byte payload through the UART TX engine.
module esp8266_encode #(
    parameter int PROMPT_TIMEOUT = 50_000_000
) (
    input logic              clk,
    input logic              rst,
    esp8266_encode_if.slave  bus
);
    localparam int CW = (PROMPT_TIMEOUT > 2) ? $clog2(PROMPT_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PROMPT_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, HDR, PROMPT, PAY} state_t;
    typedef enum logic [1:0] {ISSUE, WAIT_HI, WAIT_LO} step_t;

    state_t        state;
    step_t         step;
    logic [3:0]    idx;
    logic [23:0]   pl;
    logic [CW-1:0] cnt;
    logic          rx_q;
    logic          tx_start_q;
    logic [7:0]    tx_data_q;
    logic          busy_q;
    logic          done_q;
    logic          timeout_q;
    logic [7:0]    cur_byte;
    logic          last_byte;
    logic          rx_fall;

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.timeout  = timeout_q;

    assign rx_fall   = rx_q & ~bus.rx_int;
    assign last_byte = (state == HDR) ? (idx == 4'd13) : (idx == 4'd2);

    always_comb begin
        cur_byte = 8'h00;
        if (state == PAY) begin
            case (idx)
                4'd0:    cur_byte = pl[23:16];
                4'd1:    cur_byte = pl[15:8];
                default: cur_byte = pl[7:0];
            endcase
        end else begin
            case (idx)
                4'd0:    cur_byte = 8'h41;
                4'd1:    cur_byte = 8'h54;
                4'd2:    cur_byte = 8'h2B;
                4'd3:    cur_byte = 8'h43;
                4'd4:    cur_byte = 8'h49;
                4'd5:    cur_byte = 8'h50;
                4'd6:    cur_byte = 8'h53;
                4'd7:    cur_byte = 8'h45;
                4'd8:    cur_byte = 8'h4E;
                4'd9:    cur_byte = 8'h44;
                4'd10:   cur_byte = 8'h3D;
                4'd11:   cur_byte = 8'h33;
                4'd12:   cur_byte = 8'h0D;
                default: cur_byte = 8'h0A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            step       <= ISSUE;
            idx        <= '0;
            pl         <= '0;
            cnt        <= '0;
            rx_q       <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            rx_q       <= bus.rx_int;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.send) begin
                        state  <= HDR;
                        step   <= ISSUE;
                        idx    <= '0;
                        pl     <= bus.payload;
                        busy_q <= 1'b1;
                    end
                end
                HDR, PAY: begin
                    case (step)
                        ISSUE: begin
                            if (!bus.tx_busy) begin
                                tx_start_q <= 1'b1;
                                tx_data_q  <= cur_byte;
                                step       <= WAIT_HI;
                            end
                        end
                        WAIT_HI: if (bus.tx_busy) step <= WAIT_LO;
                        default: begin
                            if (!bus.tx_busy) begin
                                step <= ISSUE;
                                idx  <= idx + 4'd1;
                                if (last_byte) begin
                                    if (state == HDR) begin
                                        state <= PROMPT;
                                        cnt   <= '0;
                                    end else begin
                                        state  <= IDLE;
                                        done_q <= 1'b1;
                                        busy_q <= 1'b0;
                                    end
                                end
                            end
                        end
                    endcase
                end
                PROMPT: begin
                    // A prompt landing on the terminal count still wins.
                    if (rx_fall && bus.rx_data == 8'h3E) begin
                        state <= PAY;
                        step  <= ISSUE;
                        idx   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/esp8266_encode.md
# esp8266_encode

Transmit-side companion to the ESP8266 response decoder. On a `send` pulse it drives the UART transmitter with the AT command `AT+CIPSEND=3\r\n`. It then waits for the module's `>` prompt on the UART receive path and sends a latched 3-byte ASCII payload. It sits between the application logic and the UART TX byte engine, and snoops the same UART RX byte stream the decoder consumes.

## Interface
Parameters:
- `PROMPT_TIMEOUT`, default 50_000_000: cycles allowed in prompt wait (1 s at 50 MHz); minimum 2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `send`  in  1  start request, sampled each cycle; ignored while `busy`=1.
- `payload`  in  24  three ASCII bytes; [23:16] is sent first; latched when `send` is accepted.
- `tx_busy`  in  1  UART TX busy flag; high while a byte is shifting out.
- `tx_start`  out  1  one-cycle load strobe to UART TX.
- `tx_data`  out  8  byte to transmit; valid while `tx_start`=1 and held until the next load.
- `rx_int`  in  1  UART RX busy flag; a high-to-low transition, sampled in `clk`, marks `rx_data` valid.
- `rx_data`  in  8  last received byte.
- `busy`  out  1  high from send acceptance until `done` or `timeout`.
- `done`  out  1  one-cycle pulse: payload fully transmitted.
- `timeout`  out  1  one-cycle pulse: prompt not received within `PROMPT_TIMEOUT`.

## Operation
- Reset values: `tx_start`=0, `tx_data`=8'h00, `busy`=0, `done`=0, `timeout`=0. State is IDLE, all counters are 0, and the `rx_int` edge register is 0.
- States:
  - IDLE: waits for `send`.
  - HDR: 14 header bytes, index 0..13: 41 54 2B 43 49 50 53 45 4E 44 3D 33 0D 0A.
  - PROMPT: waits for `>`.
  - PAY: 3 payload bytes, index 0..2.
- IDLE -> HDR on `send`=1. The same edge latches `payload`, clears the byte index and sets `busy`.
- Per-byte handshake, in both HDR and PAY, uses three sub-steps:
  - ISSUE: wait for `tx_busy`=0, then pulse `tx_start` for one cycle with `tx_data` = current byte.
  - WAIT_HI: wait for `tx_busy`=1.
  - WAIT_LO: wait for `tx_busy`=0, then advance the index.
- After header index 13 completes, go to PROMPT and clear the timeout counter.
- PROMPT, on a detected `rx_int` falling edge:
  - `rx_data`=8'h3E: go to PAY with index 0.
  - Any other byte: ignored.
- PROMPT, timeout: the counter increments every cycle. When it reaches `PROMPT_TIMEOUT`-1 with no prompt, pulse `timeout`, clear `busy` and go to IDLE.
- PAY: after index 2 completes, pulse `done`, clear `busy` and go to IDLE.
- RX bytes arriving outside PROMPT (including an early `>` during HDR) are ignored.
- Prompt edge and timeout terminal count in the same cycle: prompt wins; no `timeout` pulse.
- `send` while `busy`: dropped, not queued. `payload` changes after acceptance have no effect.
- `rst` mid-operation: immediate return to reset values. A `tx_start` pulse in flight is cut off, and any partial command is abandoned.

## Timing
- `send` high at edge N: `busy`=1 after edge N. With `tx_busy` low, `tx_start` is high in cycle N+1 with `tx_data`=8'h41.
- Each byte costs 1 issue cycle plus the TX engine busy time plus 1 cycle to observe `tx_busy` falling.
- An `rx_int` falling edge is detected one cycle after the sampled transition. The PROMPT -> PAY transition happens on that edge, and the first payload `tx_start` can occur in the next cycle.
- `done` is high for the single cycle after the third payload byte's `tx_busy` is seen low; `busy` falls in that same cycle.
- `timeout` is high for exactly one cycle, `PROMPT_TIMEOUT` cycles after entering PROMPT.
- `tx_start` is never high for two consecutive cycles.
- `tx_start` is never asserted while `tx_busy`=1.

## Test plan
- Nominal: `payload`=24'h313233, `send` pulse, TX model busy for 10 cycles per byte, `>` injected 100 cycles after the header. Required:
  - 14 `tx_start` pulses carrying 41 54 2B 43 49 50 53 45 4E 44 3D 33 0D 0A.
  - Then 31 32 33.
  - One `done` pulse; `busy` low afterwards.
- Timeout: `PROMPT_TIMEOUT`=200 and no prompt. Required: `timeout` pulses exactly 200 cycles after the last header byte completes, and no payload `tx_start` occurs.
- Wrong prompt: inject 8'h4F then 8'h3E in PROMPT. Required: only 8'h3E releases the payload; an early 8'h3E during HDR does not.
- Back-pressure: hold `tx_busy`=1 for 50 cycles before the first byte. Required: the first `tx_start` occurs in the cycle after `tx_busy` falls, and the byte order is unchanged.
- Request during busy: a second `send` with `payload`=24'h343536 mid-header. Required: ignored; the payload sent is still 31 32 33.
- Reset mid-payload: assert `rst` after the 2nd payload byte. Required: all outputs return to reset values immediately; a fresh `send` restarts from 8'h41.
